link_tx_scheduler: RTL and testbench

Transmit-side controller for the 4-phase, 6-bit link that feeds the frame receiver. It arbitrates round-robin between NUM_REQ frame sources and captures the winning frame. It then sequences one header word followed by ceil(FRAME_BITS/4) data nibbles, using req/ack four-phase handshakes with an odd-parity bit and a last flag. It sits in the sender clock domain and drives the link wires directly.

---
 rtl/link_tx_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_link_tx_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_tx_scheduler.sv
// Round-robin transmit scheduler for the 4-phase 6-bit link: header + nibble words with odd parity.
// Define LINK_TX_STATS_EN to add the frame_cnt/abort_cnt statistics outputs.
module link_tx_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int FRAME_BITS = 1500,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk_sender,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_error,
  output logic                          wire_req,
  output logic [5:0]                    wire_data_deliver,
  input  logic                          wire_ack,
  output logic                          busy
`ifdef LINK_TX_STATS_EN
  ,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   abort_cnt
`endif
);

  localparam int NW  = (FRAME_BITS + 3) / 4;
  localparam int SRW = NW * 4;
  localparam int WCW = $clog2(NW + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0]   req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic [NUM_REQ-1:0]   req_error_q, req_error_d;
  logic                 wire_req_q, wire_req_d;
  logic [5:0]           wire_data_q, wire_data_d;
  logic                 ack_meta_q, ack_meta_d;
  logic                 ack_s_q, ack_s_d;
  logic [SRW-1:0]       shreg_q, shreg_d;

  logic [IDW-1:0]        win_id;
  logic [FRAME_BITS-1:0] win_frame;
  logic [IDW-1:0]        ptr_next;
  logic                  tmo;
  logic                  do_abort;
  logic                  do_done;
  int                    arb_best;
  int                    arb_dist;

`ifdef LINK_TX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;
`endif

  // Parity bit makes the XOR of all six wire bits equal to 1.
  function automatic logic [5:0] make_word(input logic [3:0] nib, input logic last);
    make_word = {~(^{last, nib}), last, nib};
  endfunction

  always_comb begin
    arb_best  = NUM_REQ;
    arb_dist  = 0;
    win_id    = '0;
    win_frame = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      arb_dist = j - int'(ptr_q);
      if (arb_dist < 0) arb_dist = arb_dist + NUM_REQ;
      if (req_valid[j] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        win_id    = IDW'(j);
        win_frame = req_data[j*FRAME_BITS +: FRAME_BITS];
      end
    end
  end

  assign ptr_next = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
  assign tmo      = (tcnt_q == TCW'(TIMEOUT - 1));

  always_comb begin
    ack_meta_d  = wire_ack;
    ack_s_d     = ack_meta_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;
    req_grant_d = req_grant_q;
    req_done_d  = '0;
    req_error_d = '0;
    wire_req_d  = wire_req_q;
    wire_data_d = wire_data_q;
    shreg_d     = shreg_q;
    do_abort    = 1'b0;
    do_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_grant_d = NUM_REQ'(1) << win_id;
          id_d        = win_id;
          shreg_d     = SRW'(win_frame);
          wire_data_d = make_word(4'(win_id), 1'b0);
          wire_req_d  = 1'b1;
          wcnt_d      = '0;
          tcnt_d      = '0;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (ack_s_q) begin
          wire_req_d = 1'b0;
          tcnt_d     = '0;
          state_d    = ST_RELEASE;
        end else if (tmo) begin
          do_abort = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s_q) begin
          if (wcnt_q == WCW'(NW)) begin
            do_done = 1'b1;
          end else begin
            wire_data_d = make_word(shreg_q[3:0], wcnt_q == WCW'(NW - 1));
            shreg_d     = shreg_q >> 4;
            wcnt_d      = wcnt_q + 1'b1;
            wire_req_d  = 1'b1;
            tcnt_d      = '0;
            state_d     = ST_DRIVE;
          end
        end else if (tmo) begin
          do_abort = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!ack_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_abort) begin
      wire_req_d  = 1'b0;
      req_error_d = req_grant_q;
      req_grant_d = '0;
      ptr_d       = ptr_next;
      state_d     = ST_ABORT;
    end
    if (do_done) begin
      req_done_d  = req_grant_q;
      req_grant_d = '0;
      ptr_d       = ptr_next;
      state_d     = ST_IDLE;
    end
  end

`ifdef LINK_TX_STATS_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q + (do_done ? 16'd1 : 16'd0);
    abort_cnt_d = abort_cnt_q + (do_abort ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk_sender or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

  always_ff @(posedge clk_sender or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      req_grant_q <= '0;
      req_done_q  <= '0;
      req_error_q <= '0;
      wire_req_q  <= 1'b0;
      wire_data_q <= '0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      req_grant_q <= req_grant_d;
      req_done_q  <= req_done_d;
      req_error_q <= req_error_d;
      wire_req_q  <= wire_req_d;
      wire_data_q <= wire_data_d;
      ack_meta_q  <= ack_meta_d;
      ack_s_q     <= ack_s_d;
    end
  end

  // Frame shift register is pure datapath and is always loaded before use.
  always_ff @(posedge clk_sender) begin
    shreg_q <= shreg_d;
  end

  assign req_grant         = req_grant_q;
  assign req_done          = req_done_q;
  assign req_error         = req_error_q;
  assign wire_req          = wire_req_q;
  assign wire_data_deliver = wire_data_q;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Bench for link_tx_scheduler: vector table, corner-case sequences and randomized frames vs a word-level model.
module tb_link_tx_scheduler;

  localparam int NUM_REQ    = 3;
  localparam int FRAME_BITS = 10;
  localparam int TIMEOUT    = 16;

  logic        clk_sender;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [29:0] req_data;
  logic [2:0]  req_grant;
  logic [2:0]  req_done;
  logic [2:0]  req_error;
  logic        wire_req;
  logic [5:0]  wire_data_deliver;
  logic        wire_ack;
  logic        busy;
`ifdef LINK_TX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] abort_cnt;
`endif

  int         errors = 0;
  int         checks = 0;
  int         rsp_delay = 3;
  bit         rsp_en = 1'b1;
  bit         chk_en = 1'b0;
  int         exp_frames = 0;
  int         exp_aborts = 0;
  logic [5:0] rx_q[$];

  link_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .FRAME_BITS(FRAME_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_sender(clk_sender),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_grant(req_grant),
    .req_done(req_done),
    .req_error(req_error),
    .wire_req(wire_req),
    .wire_data_deliver(wire_data_deliver),
    .wire_ack(wire_ack),
    .busy(busy)
`ifdef LINK_TX_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .abort_cnt(abort_cnt)
`endif
  );

  initial begin
    clk_sender = 1'b0;
    forever #5 clk_sender = ~clk_sender;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required $finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [5:0] exp_word(input int nib, input int last);
    int ones;
    ones = last;
    for (int b = 0; b < 4; b++) ones += (nib >> b) & 1;
    return {((ones % 2) == 0) ? 1'b1 : 1'b0, (last != 0) ? 1'b1 : 1'b0, 4'(nib)};
  endfunction

  function automatic logic [23:0] model_words(input int id, input int frame);
    logic [23:0] r;
    r = '0;
    r[23:18] = exp_word(id, 0);
    for (int k = 1; k <= 3; k++)
      r[(3-k)*6 +: 6] = exp_word((frame >> (4*(k-1))) & 15, (k == 3) ? 1 : 0);
    return r;
  endfunction

  function automatic int arb(input int p, input logic [2:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (p + k) % NUM_REQ;
      if (((v >> c) & 3'b001) != 3'b000) return c;
    end
    return 0;
  endfunction

  // ---------------- link responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    wire_ack = 1'b0;
    forever begin
      @(posedge clk_sender);
      #1;
      if (!wire_ack) begin
        if (wire_req && rsp_en) begin
          if (cnt >= rsp_delay) begin
            rx_q.push_back(wire_data_deliver);
            wire_ack = 1'b1;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end else begin
        if (!wire_req) begin
          if (cnt >= rsp_delay) begin
            wire_ack = 1'b0;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  // ---------------- handshake ordering monitor ----------------
  initial begin
    logic [5:0] pd;
    logic       pr, pa;
    pd = '0; pr = 1'b0; pa = 1'b0;
    forever begin
      @(negedge clk_sender);
      if (chk_en) begin
        if (wire_data_deliver !== pd) begin
          checks++;
          if (pr || pa) begin
            errors++;
            $display("FAIL proto_data_stable: data %0h->%0h while req=%0b ack=%0b, required both 0",
                     pd, wire_data_deliver, pr, pa);
          end
        end
        if (wire_req && !pr) begin
          checks++;
          if (pa) begin
            errors++;
            $display("FAIL proto_req_rise: wire_req rose with ack=%0b, required ack=0", pa);
          end
        end
      end
      pd = wire_data_deliver;
      pr = wire_req;
      pa = wire_ack;
    end
  end

  task automatic run_frame(input logic [2:0] v, input logic [29:0] d, input logic [2:0] eg,
                           input logic [23:0] ew, input string nm);
    int         n;
    bit         hold_ok;
    logic [2:0] dn;
    rx_q.delete();
    @(negedge clk_sender);
    req_valid = v;
    req_data  = d;
    @(negedge clk_sender);
    chk({nm, "_wire_req"}, 32'(wire_req), 32'd1);
    chk({nm, "_grant"}, 32'(req_grant), 32'(eg));
    req_valid = '0;
    req_data  = 30'($urandom);
    hold_ok = 1'b1;
    n = 0;
    while (req_done == 3'b000 && n < 400) begin
      @(negedge clk_sender);
      n++;
      if (req_done == 3'b000 && req_grant !== eg) hold_ok = 1'b0;
    end
    dn = req_done;
    chk({nm, "_done"}, 32'(dn), 32'(eg));
    chk({nm, "_grant_held"}, 32'(hold_ok), 32'd1);
    chk({nm, "_nwords"}, rx_q.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_word%0d", nm, k), (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hFFFF,
          32'(ew[(3-k)*6 +: 6]));
    exp_frames++;
  endtask

  task automatic wait_ack_low();
    int n;
    n = 0;
    while (wire_ack && n < 40) begin
      @(negedge clk_sender);
      n++;
    end
    chk("ack_low_before_release", 32'(wire_ack), 32'd0);
  endtask

  task automatic apply_reset();
    chk_en = 1'b0;
    @(negedge clk_sender);
    #2 rst_n = 1'b0;
    wait_ack_low();
    @(negedge clk_sender);
    rst_n = 1'b1;
    @(negedge clk_sender);
    chk_en = 1'b1;
    exp_frames = 0;
    exp_aborts = 0;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [29:0] data;
    logic [2:0]  grant;
    logic [23:0] words;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int         ptr, id, n, fr;
    logic [2:0] cur, err, v;
    logic [29:0] d;

    tbl[0] = '{3'b010, 30'h000AD400, 3'b010, {6'h01, 6'h25, 6'h0B, 6'h32}};
    tbl[1] = '{3'b011, 30'h000003FF, 3'b001, {6'h20, 6'h2F, 6'h2F, 6'h13}};
    tbl[2] = '{3'b101, 30'h155003FF, 3'b100, {6'h02, 6'h25, 6'h25, 6'h31}};
    tbl[3] = '{3'b110, 30'h2AA30C00, 3'b010, {6'h01, 6'h23, 6'h2C, 6'h10}};

    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    repeat (3) @(posedge clk_sender);
    @(negedge clk_sender);
    chk("rst_grant", 32'(req_grant), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_error", 32'(req_error), 32'd0);
    chk("rst_wire_req", 32'(wire_req), 32'd0);
    chk("rst_wire_data", 32'(wire_data_deliver), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sender);
    chk_en = 1'b1;

    rsp_delay = 3;
    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].valid, tbl[i].data, tbl[i].grant, tbl[i].words, $sformatf("vec%0d", i));

    // Round robin with all requesters held, then 3'b101 after serving 0.
    apply_reset();
    ptr = 0;
    rsp_delay = 1;
    @(negedge clk_sender);
    cur = 3'b111;
    req_valid = cur;
    req_data = 30'($urandom);
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_grant == 3'b000 && n < 50) begin
        @(negedge clk_sender);
        n++;
      end
      id = arb(ptr, cur);
      chk($sformatf("rr_grant%0d", g), 32'(req_grant), 32'(3'b001 << id));
      ptr = (id + 1) % NUM_REQ;
      if (g == 3) cur = 3'b101;
      if (g == 4) cur = 3'b000;
      req_valid = cur;
      n = 0;
      while (req_grant != 3'b000 && n < 300) begin
        @(negedge clk_sender);
        n++;
      end
      exp_frames++;
    end

    // Timeout: responder silent.
    rsp_en = 1'b0;
    @(negedge clk_sender);
    req_valid = 3'b011;
    n = 0;
    while (req_grant == 3'b000 && n < 50) begin
      @(negedge clk_sender);
      n++;
    end
    id = arb(ptr, 3'b011);
    chk("tmo_grant", 32'(req_grant), 32'(3'b001 << id));
    chk("tmo_req_high", 32'(wire_req), 32'd1);
    n = 0;
    err = '0;
    while (wire_req && n < 100) begin
      @(negedge clk_sender);
      n++;
      if (req_error != 3'b000) err = req_error;
    end
    chk("tmo_req_len", n, TIMEOUT);
    chk("tmo_error", 32'(err), 32'(3'b001 << id));
    chk("tmo_grant_clr", 32'(req_grant), 32'd0);
    exp_aborts++;
    ptr = (id + 1) % NUM_REQ;
    rsp_en = 1'b1;
    n = 0;
    while (req_grant == 3'b000 && n < 50) begin
      @(negedge clk_sender);
      n++;
    end
    id = arb(ptr, 3'b011);
    chk("tmo_next_grant", 32'(req_grant), 32'(3'b001 << id));
    req_valid = '0;
    n = 0;
    while (req_done == 3'b000 && n < 300) begin
      @(negedge clk_sender);
      n++;
    end
    chk("tmo_next_done", 32'(req_done), 32'(3'b001 << id));
    exp_frames++;
    ptr = (id + 1) % NUM_REQ;
`ifdef LINK_TX_STATS_EN
    @(negedge clk_sender);
    chk("stats_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("stats_abort_cnt", 32'(abort_cnt), 32'(exp_aborts));
`endif

    // Asynchronous reset during data word 2.
    rsp_delay = 3;
    rx_q.delete();
    @(negedge clk_sender);
    req_valid = 3'b100;
    req_data = 30'($urandom);
    n = 0;
    while (req_grant == 3'b000 && n < 50) begin
      @(negedge clk_sender);
      n++;
    end
    req_valid = '0;
    n = 0;
    while (rx_q.size() < 2 && n < 300) begin
      @(negedge clk_sender);
      n++;
    end
    n = 0;
    while (wire_req && n < 50) begin
      @(negedge clk_sender);
      n++;
    end
    n = 0;
    while (!wire_req && n < 50) begin
      @(negedge clk_sender);
      n++;
    end
    chk("mid_word2_driven", 32'(wire_req), 32'd1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wire_req", 32'(wire_req), 32'd0);
    chk("arst_wire_data", 32'(wire_data_deliver), 32'd0);
    chk("arst_grant", 32'(req_grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    wait_ack_low();
    @(negedge clk_sender);
    rst_n = 1'b1;
    @(negedge clk_sender);
    chk_en = 1'b1;
    exp_frames = 0;
    exp_aborts = 0;
    ptr = 0;
    d = 30'($urandom);
    run_frame(3'b111, d, 3'b001, model_words(0, int'(d[9:0])), "post_rst");
    ptr = 1;

    // Randomized frames against the model.
    for (int t = 0; t < 20; t++) begin
      v = 3'($urandom_range(1, 7));
      d = 30'($urandom);
      rsp_delay = $urandom_range(1, 4);
      id = arb(ptr, v);
      fr = int'((d >> (id * FRAME_BITS)) & 30'h3FF);
      run_frame(v, d, 3'(3'b001 << id), model_words(id, fr), $sformatf("rnd%0d", t));
      ptr = (id + 1) % NUM_REQ;
    end

    repeat (4) @(negedge clk_sender);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
